uart_rx_edge_bit_sampler: RTL and testbench
===========================================

// Module: uart_rx_edge_bit_sampler
// PURPOSE
//  Oversampling timing and data-recovery stage of the UART receiver. Sits directly upstream of
//  the RX control FSM. Counts oversampling edges and bit periods (edge_cnt/bit_cnt to the FSM)
//  and recovers each serial bit by 3-sample majority vote around mid-bit (sampled_bit to the
//  start/parity/stop checkers and the deserializer). Driven by the FSM's enable/dat_samp_en.
// PARAMETERS
//  PRESCALE_W   6   width of prescale / edge_cnt
//  BIT_CNT_W    4   width of bit_cnt
//  BIT_CNT_MAX  15  bit_cnt saturation value
// PORTS
//  clk           in   1           receiver clock (prescale x baud)
//  rst           in   1           synchronous, active-high reset
//  RX_IN         in   1           serial line, idle high
//  enable        in   1           FSM: run counters (low = clear counters)
//  dat_samp_en   in   1           FSM: enable sampling/vote
//  prescale      in   PRESCALE_W  oversampling ratio; legal 8, 16, 32
//  edge_cnt      out  PRESCALE_W  edge index inside current bit, 0..ps_l-1
//  bit_cnt       out  BIT_CNT_W   completed bit periods since enable rose
//  sampled_bit   out  1           majority-voted bit value
//  samp_valid    out  1           1-cycle pulse: sampled_bit updated
//  prescale_err  out  1           latched prescale was illegal
// BEHAVIOUR
//  - One clock, one synchronous active-high reset. No other clock or reset.
//  - Reset (rst=1 at posedge): edge_cnt=0, bit_cnt=0, sampled_bit=1, samp_valid=0,
//    prescale_err=0, ps_l=8, s0/s1/s2=1.
//  - Prescale latch ps_l: loaded every cycle enable=0; frozen while enable=1.
//    A mid-frame prescale change is ignored until enable next drops.
//    Illegal value (not 8/16/32) -> ps_l=8, prescale_err=1; legal -> prescale_err=0.
//    prescale_err updates only on enable=0 cycles.
//  - Counters (registered):
//    enable=0 -> edge_cnt<=0, bit_cnt<=0 (clear wins over every other event).
//    enable=1, edge_cnt!=ps_l-1 -> edge_cnt<=edge_cnt+1.
//    enable=1, edge_cnt==ps_l-1 -> edge_cnt<=0, bit_cnt<=bit_cnt+1 (saturate at BIT_CNT_MAX).
//  - Sampling: h = ps_l>>1. With enable & dat_samp_en, RX path captured into
//    s0 @ edge_cnt==h-1, s1 @ edge_cnt==h, s2 @ edge_cnt==h+1 (prescale 8 -> edges 3,4,5).
//  - Vote: on cycle edge_cnt==h+1 with sampling active: sampled_bit<=maj(s0,s1,rx),
//    samp_valid<=1. Result visible when edge_cnt==h+2. samp_valid=0 on all other cycles.
//  - dat_samp_en=0: no capture, samp_valid=0, sampled_bit holds its last value.
//  - Dropping dat_samp_en between s0 and vote: vote suppressed, no samp_valid pulse.
//    Partial samples are discarded; the next bit period starts fresh.
//  - enable=0 for one cycle mid-frame: counters restart from 0; sampled_bit holds.
//  - Latency: RX_IN -> vote input 0 cycles (combinational into capture flop);
//    vote -> samp_valid 1 cycle.
// CONFIGURATION
//  RX_SYNC_EN defined: RX_IN passes through a 2-flop synchronizer (flops reset to 1) before
//    the sample flops. This adds 2 clk of latency on the RX path; counter timing is unchanged.
//  RX_SYNC_EN undefined: RX_IN feeds the sample flops directly. The top level guarantees
//    synchronous RX_IN.
// TESTING
//  T1 ps=8, RX_IN=0, enable=dat_samp_en=1 for 16 clk -> edge_cnt 0..7 twice; bit_cnt 0->1->2;
//     samp_valid pulses when edge_cnt==6 (twice); sampled_bit=0.
//  T2 ps=8, RX_IN=0 except 1 only at edge 4 -> sampled_bit=0 (glitch voted out).
//     RX_IN=1 at edges 3,4 -> sampled_bit=1.
//  T3 prescale=12 with enable=0, then enable=1 -> prescale_err=1; edge_cnt wraps at 7.
//     prescale=16 with enable=0 -> prescale_err=0 next clk.
//  T4 ps=16, enable=1; at bit_cnt=3 set prescale=32 -> wrap stays at 15.
//     Drop enable for 1 clk -> edge_cnt=0, bit_cnt=0 next clk; ps_l becomes 32.
//  T5 ps=8, enable held 20 bit periods -> bit_cnt reaches 15 and holds; edge_cnt keeps wrapping.
//  T6 rst=1 mid-frame (edge_cnt=5, bit_cnt=4) -> all outputs at reset values next clk.
//     With RX_SYNC_EN: T1 vote result shifts by exactly 2 clk of RX latency.

Source files
------------

// File: rtl/uart_rx_edge_bit_sampler_if.sv
// uart_rx_edge_bit_sampler_if: FSM <-> edge/bit sampler signal bundle
interface uart_rx_edge_bit_sampler_if #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
);
  logic                  RX_IN;
  logic                  enable;
  logic                  dat_samp_en;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  sampled_bit;
  logic                  samp_valid;
  logic                  prescale_err;
  modport master (
    output RX_IN, enable, dat_samp_en, prescale,
    input  edge_cnt, bit_cnt, sampled_bit, samp_valid, prescale_err
  );
  modport slave (
    input  RX_IN, enable, dat_samp_en, prescale,
    output edge_cnt, bit_cnt, sampled_bit, samp_valid, prescale_err
  );
endinterface

// File: rtl/uart_rx_edge_bit_sampler.sv
// uart_rx_edge_bit_sampler: oversampling edge/bit counters and 3-sample mid-bit majority vote (RX_SYNC_EN adds a 2-flop RX synchronizer)
module uart_rx_edge_bit_sampler #(
  parameter int PRESCALE_W  = 6,
  parameter int BIT_CNT_W   = 4,
  parameter int BIT_CNT_MAX = 15
) (
  input logic clk,
  input logic rst,
  uart_rx_edge_bit_sampler_if.slave bus
);
  logic [PRESCALE_W-1:0] ps_l, h;
  logic rx, samp, ps_ok, last, vote, s0, s1, v0, v1;
  assign ps_ok = bus.prescale inside {PRESCALE_W'(8), PRESCALE_W'(16), PRESCALE_W'(32)};
  assign h     = ps_l >> 1;
  assign samp  = bus.enable & bus.dat_samp_en;
  assign last  = bus.edge_cnt == ps_l - 1'b1;
  assign vote  = samp && bus.edge_cnt == h + 1'b1 && v1;
`ifdef RX_SYNC_EN
  logic [1:0] sync;
  // two-flop synchronizer, idle-high reset so no false start bit
  always_ff @(posedge clk)
    if (rst) sync <= 2'b11;
    else sync <= {sync[0], bus.RX_IN};
  assign rx = sync[1];
`else
  assign rx = bus.RX_IN;
`endif
  // prescale is latched only while idle so a frame keeps one bit period
  always_ff @(posedge clk)
    if (rst) begin
      ps_l <= PRESCALE_W'(8);
      bus.prescale_err <= 1'b0;
    end else if (!bus.enable) begin
      ps_l <= ps_ok ? bus.prescale : PRESCALE_W'(8);
      bus.prescale_err <= !ps_ok;
    end
  // edge counter wraps at ps_l-1 and advances the saturating bit counter
  always_ff @(posedge clk)
    if (rst || !bus.enable) begin
      bus.edge_cnt <= '0;
      bus.bit_cnt  <= '0;
    end else begin
      bus.edge_cnt <= last ? '0 : bus.edge_cnt + 1'b1;
      bus.bit_cnt  <= (last && bus.bit_cnt != BIT_CNT_W'(BIT_CNT_MAX)) ? bus.bit_cnt + 1'b1 : bus.bit_cnt;
    end
  // capture the two early samples; v0/v1 track an unbroken capture run this bit
  always_ff @(posedge clk)
    if (rst) begin
      s0 <= 1'b1;
      s1 <= 1'b1;
      v0 <= 1'b0;
      v1 <= 1'b0;
    end else begin
      if (samp && bus.edge_cnt == h - 1'b1) begin
        s0 <= rx;
        v0 <= 1'b1;
      end
      if (samp && bus.edge_cnt == h) begin
        s1 <= rx;
        v1 <= v0;
      end
      if (!samp || bus.edge_cnt == h + 1'b1) begin
        v0 <= 1'b0;
        v1 <= 1'b0;
      end
    end
  // third sample is taken live and voted in the same cycle
  always_ff @(posedge clk)
    if (rst) begin
      bus.sampled_bit <= 1'b1;
      bus.samp_valid  <= 1'b0;
    end else begin
      bus.samp_valid <= vote;
      if (vote) bus.sampled_bit <= (s0 & s1) | (s0 & rx) | (s1 & rx);
    end
endmodule

// File: tb/tb_uart_rx_edge_bit_sampler.sv
// tb_uart_rx_edge_bit_sampler: randomized + directed bench against a per-bit-period sample model
module tb_uart_rx_edge_bit_sampler;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  uart_rx_edge_bit_sampler_if bus ();
  uart_rx_edge_bit_sampler dut (.clk(clk), .rst(rst), .bus(bus));
  int n_cmp = 0;
  int n_bad = 0;
  int m_edge, m_bit, m_ps, m_sb, m_sv, m_err;
  bit got [64];
  bit smp [64];
  bit rxd0, rxd1;
  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask
  task automatic drive(input bit rx, input bit en, input bit dse, input int ps);
    bus.RX_IN = rx;
    bus.enable = en;
    bus.dat_samp_en = dse;
    bus.prescale = 6'(ps);
  endtask
  task automatic step();
    int rx_eff, h, ones, n_edge, n_bit, n_sb, n_sv, n_ps, n_err;
    bit samp, legal;
`ifdef RX_SYNC_EN
    rx_eff = rxd1;
`else
    rx_eff = bus.RX_IN;
`endif
    h = m_ps / 2;
    samp = bus.enable && bus.dat_samp_en;
    legal = bus.prescale == 8 || bus.prescale == 16 || bus.prescale == 32;
    n_sb = m_sb;
    n_sv = 0;
    if (samp && m_edge == h + 1 && got[h-1] && got[h]) begin
      ones = smp[h-1] + smp[h] + rx_eff;
      n_sb = ones >= 2 ? 1 : 0;
      n_sv = 1;
    end
    n_ps = bus.enable ? m_ps : (legal ? int'(bus.prescale) : 8);
    n_err = bus.enable ? m_err : (legal ? 0 : 1);
    if (!bus.enable) begin
      n_edge = 0;
      n_bit = 0;
    end else if (m_edge == m_ps - 1) begin
      n_edge = 0;
      n_bit = m_bit < 15 ? m_bit + 1 : 15;
    end else begin
      n_edge = m_edge + 1;
      n_bit = m_bit;
    end
    if (rst) begin
      n_edge = 0; n_bit = 0; n_sb = 1; n_sv = 0; n_ps = 8; n_err = 0;
    end
    if (rst || !samp || m_edge == m_ps - 1) begin
      foreach (got[i]) got[i] = 0;
    end else begin
      got[m_edge] = 1;
      smp[m_edge] = rx_eff[0];
    end
    rxd1 = rst ? 1'b1 : rxd0;
    rxd0 = rst ? 1'b1 : bus.RX_IN;
    @(posedge clk);
    #1;
    m_edge = n_edge; m_bit = n_bit; m_sb = n_sb; m_sv = n_sv; m_ps = n_ps; m_err = n_err;
    chk("edge_cnt", int'(bus.edge_cnt), m_edge);
    chk("bit_cnt", int'(bus.bit_cnt), m_bit);
    chk("sampled_bit", int'(bus.sampled_bit), m_sb);
    chk("samp_valid", int'(bus.samp_valid), m_sv);
    chk("prescale_err", int'(bus.prescale_err), m_err);
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  initial begin
    int pick [8] = '{8, 16, 32, 12, 0, 63, 8, 16};
    int ps, k;
    rst = 1'b1;
    m_edge = 0; m_bit = 0; m_ps = 8; m_sb = 1; m_sv = 0; m_err = 0;
    rxd0 = 1; rxd1 = 1;
    drive(1, 0, 0, 8);
    @(negedge clk);
    run(2);
    chk("rst_sampled_bit", int'(bus.sampled_bit), 1);
    chk("rst_edge_cnt", int'(bus.edge_cnt), 0);
    rst = 1'b0;
    // T1: constant zero line, two bit periods
    drive(0, 0, 0, 8);
    run(1);
    drive(0, 1, 1, 8);
    run(16);
    chk("t1_bit_cnt", int'(bus.bit_cnt), 2);
    chk("t1_sampled_bit", int'(bus.sampled_bit), 0);
    // T2: single-sample glitch voted out, two-sample high voted in
    drive(1, 0, 0, 8);
    run(1);
    for (int i = 0; i < 24; i++) begin
      drive(m_edge == 4, 1, 1, 8);
      step();
    end
    chk("t2_glitch", int'(bus.sampled_bit), 0);
    for (int i = 0; i < 24; i++) begin
      drive(m_edge == 3 || m_edge == 4, 1, 1, 8);
      step();
    end
    chk("t2_two_high", int'(bus.sampled_bit), 1);
    // T3: illegal prescale falls back to 8
    drive(1, 0, 1, 12);
    run(1);
    chk("t3_err", int'(bus.prescale_err), 1);
    drive(1, 1, 1, 12);
    run(20);
    drive(1, 0, 1, 16);
    run(1);
    chk("t3_err_clear", int'(bus.prescale_err), 0);
    // T4: prescale change mid-frame ignored until enable drops
    drive(0, 1, 1, 16);
    k = 0;
    while (m_bit != 3 && k < 200) begin step(); k++; end
    if (k == 200) chk("t4_timeout", 0, 1);
    drive(0, 1, 1, 32);
    run(40);
    drive(0, 0, 1, 32);
    run(1);
    chk("t4_edge_clr", int'(bus.edge_cnt), 0);
    chk("t4_bit_clr", int'(bus.bit_cnt), 0);
    drive(0, 1, 1, 32);
    run(64);
    // T5: bit counter saturation
    drive(1, 0, 1, 8);
    run(1);
    drive(1, 1, 1, 8);
    run(160);
    chk("t5_bit_sat", int'(bus.bit_cnt), 15);
    // T6: reset mid-frame
    k = 0;
    drive(0, 0, 1, 8);
    run(1);
    drive(0, 1, 1, 8);
    while (!(m_edge == 5 && m_bit == 4) && k < 200) begin step(); k++; end
    if (k == 200) chk("t6_timeout", 0, 1);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    chk("t6_sampled_bit", int'(bus.sampled_bit), 1);
    // randomized traffic
    ps = 8;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) ps = pick[$urandom_range(0, 7)];
      rst = $urandom_range(0, 499) == 0;
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 39) != 0, $urandom_range(0, 9) != 0, ps);
      step();
    end
    rst = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
